// File: rtl/stream_fifo_flow_pipe.sv
// Valid/ready stream FIFO with register storage, optional empty bypass (FLOW)
// and optional full pass-through (PIPE), plus occupancy, threshold flags and flush.
module stream_fifo_flow_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int FLOW          = 1,
  parameter int PIPE          = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [CW-1:0]         count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  // Handshake: a beat transfers on a side in any cycle where valid && ready
  // at the rising edge; valid never waits on ready, ready never looks at w_valid_i.

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic FLOW_EN = (FLOW != 0);
  localparam logic PIPE_EN = (PIPE != 0);
  localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
  localparam logic [31:0]   AF_T = 32'(AFULL_THRESH);
  localparam logic [31:0]   AE_T = 32'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;

  logic empty;
  logic full;
  logic fire_w;
  logic fire_r;
  logic push;
  logic pop;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [31:0]   count_ext;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));

  assign w_ready_o = !flush_i && (!full || (PIPE_EN && r_ready_i));
  assign r_valid_o = !flush_i && (!empty || (FLOW_EN && w_valid_i));
  assign r_data_o  = (FLOW_EN && empty) ? w_data_i : mem[rd_ptr];

  assign fire_w = w_valid_i && w_ready_o;
  assign fire_r = r_valid_o && r_ready_i;
  // A beat consumed straight through the bypass is never written to storage.
  assign push   = fire_w && !(FLOW_EN && empty && r_ready_i);
  assign pop    = fire_r && !empty;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  assign wr_ptr_nxt = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_nxt = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= w_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_ext      = {{(32 - CW){1'b0}}, count_q};
  assign count_o        = count_q;
  assign almost_full_o  = (count_ext >= AF_T);
  assign almost_empty_o = (count_ext <= AE_T);

endmodule

// File: tb/tb_stream_fifo_flow_pipe.sv
// Bench for stream_fifo_flow_pipe: two instances (FLOW bypass depth 4, PIPE depth 3)
// driven per cycle, with a queue model of FIFO contents checked by a monitor.
module tb_stream_fifo_flow_pipe;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         flush_a, wv_a, wr_a, rv_a, rr_a, af_a, ae_a;
  logic [W-1:0] wd_a, rd_a;
  logic [2:0]   cnt_a;
  logic         flush_b, wv_b, wr_b, rv_b, rr_b, af_b, ae_b;
  logic [W-1:0] wd_b, rd_b;
  logic [1:0]   cnt_b;

  stream_fifo_flow_pipe #(.DATA_WIDTH(W), .FIFO_DEPTH(4), .FLOW(1), .PIPE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_a),
    .w_valid_i(wv_a), .w_ready_o(wr_a), .w_data_i(wd_a),
    .r_valid_o(rv_a), .r_ready_i(rr_a), .r_data_o(rd_a),
    .count_o(cnt_a), .almost_full_o(af_a), .almost_empty_o(ae_a)
  );

  stream_fifo_flow_pipe #(.DATA_WIDTH(W), .FIFO_DEPTH(3), .FLOW(0), .PIPE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_b),
    .w_valid_i(wv_b), .w_ready_o(wr_b), .w_data_i(wd_b),
    .r_valid_o(rv_b), .r_ready_i(rr_b), .r_data_o(rd_b),
    .count_o(cnt_b), .almost_full_o(af_b), .almost_empty_o(ae_b)
  );

  // Instance configurations as the model sees them.
  int depth_c [2] = '{4, 3};
  int flow_c  [2] = '{1, 0};
  int pipe_c  [2] = '{0, 1};
  int af_c    [2] = '{3, 2};
  int ae_c    [2] = '{1, 1};

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int cnt_start [2] = '{0, 0};
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  // Driver: one call per cycle; the other instance idles. Accepted beats join the model.
  task automatic drive(input int id, input logic fl, input logic wv,
                       input logic [W-1:0] wd, input logic rr);
    logic exp_wr;
    @(negedge clk);
    flush_a = 1'b0; wv_a = 1'b0; rr_a = 1'b0;
    flush_b = 1'b0; wv_b = 1'b0; rr_b = 1'b0;
    if (id == 0) begin
      flush_a = fl; wv_a = wv; wd_a = wd; rr_a = rr;
    end else begin
      flush_b = fl; wv_b = wv; wd_b = wd; rr_b = rr;
    end
    cnt_start[0] = exp_q_a.size();
    cnt_start[1] = exp_q_b.size();
    #1;
    exp_wr = !fl && ((cnt_start[id] < depth_c[id]) || (pipe_c[id] != 0 && rr));
    if (wv && exp_wr) begin
      if (id == 0) exp_q_a.push_back(wd);
      else         exp_q_b.push_back(wd);
    end
  endtask

  // Monitor: compares outputs against the model and retires beats the consumer takes.
  logic         m_fl, m_wv, m_rr, m_wr, m_rv, m_af, m_ae, m_exp_rv;
  logic [W-1:0] m_rd, m_cnt, m_front;
  int           m_c, m_qs;

  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      for (int id = 0; id < 2; id++) begin
        if (id == 0) begin
          m_fl = flush_a; m_wv = wv_a; m_rr = rr_a; m_wr = wr_a; m_rv = rv_a;
          m_af = af_a; m_ae = ae_a; m_rd = rd_a; m_cnt = 32'(cnt_a); m_qs = exp_q_a.size();
        end else begin
          m_fl = flush_b; m_wv = wv_b; m_rr = rr_b; m_wr = wr_b; m_rv = rv_b;
          m_af = af_b; m_ae = ae_b; m_rd = rd_b; m_cnt = 32'(cnt_b); m_qs = exp_q_b.size();
        end
        m_c = cnt_start[id];
        chk("count", m_cnt, 32'(m_c));
        chk1("almost_full", m_af, m_c >= af_c[id]);
        chk1("almost_empty", m_ae, m_c <= ae_c[id]);
        chk1("w_ready", m_wr, !m_fl && ((m_c < depth_c[id]) || (pipe_c[id] != 0 && m_rr)));
        m_exp_rv = !m_fl && ((m_c > 0) || (flow_c[id] != 0 && m_wv));
        chk1("r_valid", m_rv, m_exp_rv);
        if (m_exp_rv && m_qs > 0) begin
          m_front = (id == 0) ? exp_q_a[0] : exp_q_b[0];
          chk("r_data", m_rd, m_front);
          if (m_rr) begin
            if (id == 0) void'(exp_q_a.pop_front());
            else         void'(exp_q_b.pop_front());
          end
        end
        if (m_fl) begin
          if (id == 0) exp_q_a.delete();
          else         exp_q_b.delete();
        end
      end
    end
  end

  initial begin
    flush_a = 1'b0; wv_a = 1'b1; wd_a = 32'h5A; rr_a = 1'b0;
    flush_b = 1'b0; wv_b = 1'b1; wd_b = 32'h5B; rr_b = 1'b0;
    #1;
    // Reset state, including combinational bypass while held in reset.
    chk("rst_count_a", 32'(cnt_a), 32'd0);
    chk1("rst_af_a", af_a, 1'b0);
    chk1("rst_ae_a", ae_a, 1'b1);
    chk1("rst_w_ready_a", wr_a, 1'b1);
    chk1("rst_r_valid_a", rv_a, 1'b1);
    chk("rst_r_data_a", rd_a, 32'h5A);
    chk1("rst_r_valid_b", rv_b, 1'b0);
    chk("rst_count_b", 32'(cnt_b), 32'd0);
    flush_a = 1'b1;
    #1;
    chk1("rst_flush_w_ready_a", wr_a, 1'b0);
    chk1("rst_flush_r_valid_a", rv_a, 1'b0);
    flush_a = 1'b0; wv_a = 1'b0; wv_b = 1'b0;
    #21;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Same-cycle bypass on the FLOW instance.
    drive(0, 1'b0, 1'b1, 32'hA5, 1'b1);
    // Fill to full with the consumer stalled, then drain in order.
    drive(0, 1'b0, 1'b1, 32'h11, 1'b0);
    drive(0, 1'b0, 1'b1, 32'h22, 1'b0);
    drive(0, 1'b0, 1'b1, 32'h33, 1'b0);
    drive(0, 1'b0, 1'b1, 32'h44, 1'b0);
    drive(0, 1'b0, 1'b1, 32'h55, 1'b0);
    repeat (5) drive(0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush with two entries while both sides are active.
    drive(0, 1'b0, 1'b1, 32'h61, 1'b0);
    drive(0, 1'b0, 1'b1, 32'h62, 1'b0);
    drive(0, 1'b1, 1'b1, 32'hEE, 1'b1);
    drive(0, 1'b0, 1'b1, 32'h7E, 1'b0);
    drive(0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic on the FLOW instance, with occasional flushes.
    repeat (60) drive(0, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                      $urandom, 1'($urandom_range(0, 1)));

    // PIPE pass-through when full.
    drive(1, 1'b0, 1'b1, 32'hB1, 1'b0);
    drive(1, 1'b0, 1'b1, 32'hB2, 1'b0);
    drive(1, 1'b0, 1'b1, 32'hB3, 1'b0);
    for (int i = 1; i <= 6; i++) drive(1, 1'b0, 1'b1, 32'(i), 1'b1);
    drive(1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Pointer wrap with random stalls on the depth-3 instance.
    repeat (60) drive(1, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    repeat (4) drive(1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-stream with three entries held.
    drive(1, 1'b0, 1'b1, 32'hC1, 1'b0);
    drive(1, 1'b0, 1'b1, 32'hC2, 1'b0);
    drive(1, 1'b0, 1'b1, 32'hC3, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_count_b", 32'(cnt_b), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count_b", 32'(cnt_b), 32'd0);
    chk1("async_rst_ae_b", ae_b, 1'b1);
    chk1("async_rst_r_valid_b", rv_b, 1'b0);
    exp_q_a.delete();
    exp_q_b.delete();
    #1;
    rst_n = 1'b1;
    repeat (2) drive(1, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1, 1'b0, 1'b1, 32'h99, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) drive(0, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
